// File: rtl/bcd_operand_loader.sv
// Serial BCD operand loader: collects DIGITS digits of A, then DIGITS digits of B
// plus a carry-in, and holds the assembled operands until the adder consumes them.
module bcd_operand_loader #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din_valid,
    input  logic [3:0]            din,
    output logic                  din_ready,
    input  logic                  cin_in,
    output logic [4*DIGITS-1:0]   A,
    output logic [4*DIGITS-1:0]   B,
    output logic                  Cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Append one digit as the new least-significant nibble.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
        logic [W+3:0] t;
        t = {v, d};
        return t[W-1:0];
    endfunction

    assign din_ready = (state != HOLD);

    // Loader FSM, digit counter and registered operand outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            cnt       <= {CW{1'b0}};
            A         <= {W{1'b0}};
            B         <= {W{1'b0}};
            Cin       <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD_A, LOAD_B: begin
                    if (din_valid) begin
                        if (din > 4'd9) begin
                            err   <= 1'b1;
                            state <= LOAD_A;
                            cnt   <= {CW{1'b0}};
                            A     <= {W{1'b0}};
                            B     <= {W{1'b0}};
                            Cin   <= 1'b0;
                        end else begin
                            // The first digit of a transaction wipes the previous operands.
                            if (state == LOAD_A) begin
                                if (cnt == {CW{1'b0}}) begin
                                    A   <= shift_in({W{1'b0}}, din);
                                    B   <= {W{1'b0}};
                                    Cin <= 1'b0;
                                end else begin
                                    A <= shift_in(A, din);
                                end
                            end else begin
                                B <= shift_in(B, din);
                            end
                            if (cnt == LAST) begin
                                cnt <= {CW{1'b0}};
                                if (state == LOAD_A) begin
                                    state <= LOAD_B;
                                end else begin
                                    state     <= HOLD;
                                    Cin       <= cin_in;
                                    out_valid <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= LOAD_A;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= LOAD_A;
                    cnt       <= {CW{1'b0}};
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
